// File: rtl/fet_redirect_if.sv
// Stall, redirect-request and redirect-result signals shared by the redirect
// sources, the fetch unit and fet_redirect_ctrl.
interface fet_redirect_if;
  logic        de_stall;
  logic        exe_store_load_conflict;
  logic        readram_stall;
  logic        mem_stall;
  logic        mult_stall;
  logic        exp_req;
  logic [31:0] exp_pc;
  logic        int_req;
  logic [31:0] int_pc;
  logic        bpe_req;
  logic [31:0] bpe_pc;
  logic        jmp_req;
  logic [31:0] jmp_pc;
  logic        fet_stall;
  logic        fet_flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_busy;
  logic [15:0] redir_cnt;

  modport master (
    output de_stall, exe_store_load_conflict, readram_stall, mem_stall, mult_stall,
    output exp_req, exp_pc, int_req, int_pc, bpe_req, bpe_pc, jmp_req, jmp_pc,
    input  fet_stall, fet_flush, redir_valid, redir_pc, redir_busy, redir_cnt
  );

  modport slave (
    input  de_stall, exe_store_load_conflict, readram_stall, mem_stall, mult_stall,
    input  exp_req, exp_pc, int_req, int_pc, bpe_req, bpe_pc, jmp_req, jmp_pc,
    output fet_stall, fet_flush, redir_valid, redir_pc, redir_busy, redir_cnt
  );
endinterface

// File: rtl/fet_redirect_ctrl.sv
// Fetch redirect/flush sequencer: arbitrates exception > interrupt > mispredict > jump.
// Optional FET_REDIR_CNT_EN builds the saturating redirect counter on redir_cnt.
module fet_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           cpurst,
  fet_redirect_if.slave bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PEND  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  state_e      state_r;
  state_e      state_step_s;
  state_e      state_d_s;
  logic        flush_r;
  logic        flush_step_s;
  logic        flush_d_s;
  logic [2:0]  fcnt_r;
  logic [2:0]  fcnt_step_s;
  logic [2:0]  fcnt_d_s;
  logic [31:0] pend_pc_r;
  logic [31:0] pend_pc_step_s;
  logic        valid_r;
  logic [31:0] pc_r;
  logic        busy_r;
  logic        issue_s;
  logic [31:0] issue_pc_s;
  logic        stall_s;
  logic        urgent_s;
  logic [31:0] urgent_pc_s;
  logic        normal_s;
  logic [31:0] normal_pc_s;

  assign stall_s     = bus.de_stall | bus.exe_store_load_conflict | bus.readram_stall |
                       bus.mem_stall | bus.mult_stall;
  assign urgent_s    = bus.exp_req | bus.int_req;
  assign urgent_pc_s = bus.exp_req ? bus.exp_pc : bus.int_pc;
  assign normal_s    = bus.bpe_req | bus.jmp_req;
  assign normal_pc_s = bus.bpe_req ? bus.bpe_pc : bus.jmp_pc;

  // Redirect decision per state; an issue always lands in FLUSH with a reloaded counter.
  always_comb begin
    state_step_s   = state_r;
    flush_step_s   = flush_r;
    fcnt_step_s    = fcnt_r;
    pend_pc_step_s = pend_pc_r;
    issue_s        = 1'b0;
    issue_pc_s     = pc_r;
    case (state_r)
      ST_BOOT: begin
        issue_s    = 1'b1;
        issue_pc_s = RESET_PC;
      end
      ST_IDLE: begin
        flush_step_s = 1'b0;
        if (urgent_s) begin
          issue_s    = 1'b1;
          issue_pc_s = urgent_pc_s;
        end else if (normal_s && !stall_s) begin
          issue_s    = 1'b1;
          issue_pc_s = normal_pc_s;
        end else if (normal_s) begin
          pend_pc_step_s = normal_pc_s;
          state_step_s   = ST_PEND;
        end else begin
          state_step_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        // Older pending redirect beats any new normal request; urgent overrides it.
        if (urgent_s) begin
          issue_s    = 1'b1;
          issue_pc_s = urgent_pc_s;
        end else if (!stall_s) begin
          issue_s    = 1'b1;
          issue_pc_s = pend_pc_r;
        end else begin
          state_step_s = ST_PEND;
        end
      end
      ST_FLUSH: begin
        if (urgent_s) begin
          issue_s    = 1'b1;
          issue_pc_s = urgent_pc_s;
        end else if (fcnt_r != 3'd0) begin
          fcnt_step_s = fcnt_r - 3'd1;
        end else begin
          flush_step_s = 1'b0;
          state_step_s = ST_IDLE;
        end
      end
      default: begin
        state_step_s = ST_BOOT;
        flush_step_s = 1'b1;
      end
    endcase
  end

  assign state_d_s = issue_s ? ST_FLUSH : state_step_s;
  assign flush_d_s = issue_s ? 1'b1 : flush_step_s;
  assign fcnt_d_s  = issue_s ? FLUSH_LOAD : fcnt_step_s;

  // State and registered redirect outputs; reset restarts the BOOT sequence.
  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_r   <= ST_BOOT;
      flush_r   <= 1'b1;
      fcnt_r    <= 3'd0;
      pend_pc_r <= 32'h0000_0000;
      valid_r   <= 1'b0;
      pc_r      <= 32'h0000_0000;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_d_s;
      flush_r   <= flush_d_s;
      fcnt_r    <= fcnt_d_s;
      pend_pc_r <= pend_pc_step_s;
      valid_r   <= issue_s;
      pc_r      <= issue_s ? issue_pc_s : pc_r;
      busy_r    <= (state_d_s == ST_PEND) || (state_d_s == ST_FLUSH);
    end
  end

  assign bus.fet_stall   = stall_s;
  assign bus.fet_flush   = flush_r;
  assign bus.redir_valid = valid_r;
  assign bus.redir_pc    = pc_r;
  assign bus.redir_busy  = busy_r;

`ifdef FET_REDIR_CNT_EN
  logic        count_s;
  logic [15:0] redir_cnt_r;

  assign count_s = issue_s && (state_r != ST_BOOT);

  // Saturating count of non-boot redirects, updated alongside redir_valid.
  always_ff @(posedge clk) begin
    if (cpurst) begin
      redir_cnt_r <= 16'h0000;
    end else if (count_s && (redir_cnt_r != 16'hFFFF)) begin
      redir_cnt_r <= redir_cnt_r + 16'h0001;
    end else begin
      redir_cnt_r <= redir_cnt_r;
    end
  end

  assign bus.redir_cnt = redir_cnt_r;
`else
  assign bus.redir_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fet_redirect_ctrl.sv
// Table-driven bench for fet_redirect_ctrl: one vector per clock cycle plus a
// hand-written stall-release latency sequence.
module tb_fet_redirect_ctrl;

  localparam logic [31:0] RP = 32'h0000_1000;
  localparam logic [31:0] N  = 32'h0000_0000;
  localparam logic [4:0]  S0  = 5'b00000;
  localparam logic [4:0]  DE  = 5'b10000;
  localparam logic [4:0]  EXE = 5'b01000;
  localparam logic [4:0]  RR  = 5'b00100;
  localparam logic [4:0]  MEM = 5'b00010;
  localparam logic [4:0]  MUL = 5'b00001;
`ifdef FET_REDIR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [4:0]  st;
    logic [31:0] pe, pi, pb, pj;
    logic        ef, ev;
    logic [31:0] ep;
    logic        eb;
    logic [15:0] ec;
  } vec_t;

  logic clk;
  logic cpurst;
  int   checks;
  int   failures;
  vec_t vecs[$];

  fet_redirect_if bus();

  fet_redirect_ctrl #(.RESET_PC(RP), .FLUSH_CYCLES(2)) dut (
    .clk    (clk),
    .cpurst (cpurst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", nm, row, act, exp);
    end
  endtask

  // A request is raised exactly when its PC field in the vector is non-zero.
  task automatic add(input logic r, input logic [4:0] st, input logic [31:0] pe, input logic [31:0] pi,
                     input logic [31:0] pb, input logic [31:0] pj, input logic ef, input logic ev,
                     input logic [31:0] ep, input logic eb, input logic [15:0] ec);
    vec_t v;
    v.rst = r; v.st = st; v.pe = pe; v.pi = pi; v.pb = pb; v.pj = pj;
    v.ef = ef; v.ev = ev; v.ep = ep; v.eb = eb; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    cpurst                      = v.rst;
    bus.de_stall                = v.st[4];
    bus.exe_store_load_conflict = v.st[3];
    bus.readram_stall           = v.st[2];
    bus.mem_stall               = v.st[1];
    bus.mult_stall              = v.st[0];
    bus.exp_req = (v.pe != N); bus.exp_pc = v.pe;
    bus.int_req = (v.pi != N); bus.int_pc = v.pi;
    bus.bpe_req = (v.pb != N); bus.bpe_pc = v.pb;
    bus.jmp_req = (v.pj != N); bus.jmp_pc = v.pj;
  endtask

  initial begin
    vec_t idle_v;
    logic        seen_early;
    logic        got;
    int          lat;
    logic [15:0] exp_c;

    checks = 0;
    failures = 0;
    idle_v = '{rst: 1'b0, st: S0, pe: N, pi: N, pb: N, pj: N, ef: 1'b0, ev: 1'b0, ep: N, eb: 1'b0, ec: 16'd0};
    drive(idle_v);
    cpurst = 1'b1;

    //   rst   stall pe           pi           pb           pj            flush valid pc  busy cnt
    add(1'b1, S0,  N,           N,           N,           N,           1'b1, 1'b0, N,            1'b0, 16'd0);
    add(1'b1, S0,  N,           N,           N,           N,           1'b1, 1'b0, N,            1'b0, 16'd0);
    add(1'b1, S0,  N,           N,           N,           N,           1'b1, 1'b0, N,            1'b0, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b1, RP,           1'b1, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, RP,           1'b1, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, RP,           1'b0, 16'd0);
    add(1'b0, S0,  N,           N,           32'h100,     N,           1'b1, 1'b1, 32'h100,      1'b1, 16'd1);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, 32'h100,      1'b1, 16'd1);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h100,      1'b0, 16'd1);
    add(1'b0, MEM, N,           N,           N,           32'h200,     1'b0, 1'b0, 32'h100,      1'b1, 16'd1);
    add(1'b0, MEM, N,           N,           N,           N,           1'b0, 1'b0, 32'h100,      1'b1, 16'd1);
    add(1'b0, MEM, N,           N,           N,           N,           1'b0, 1'b0, 32'h100,      1'b1, 16'd1);
    add(1'b0, MEM, N,           N,           N,           N,           1'b0, 1'b0, 32'h100,      1'b1, 16'd1);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b1, 32'h200,      1'b1, 16'd2);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, 32'h200,      1'b1, 16'd2);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h200,      1'b0, 16'd2);
    add(1'b0, DE,  N,           N,           32'h240,     N,           1'b0, 1'b0, 32'h200,      1'b1, 16'd2);
    add(1'b0, DE,  32'h80,      N,           N,           N,           1'b1, 1'b1, 32'h80,       1'b1, 16'd3);
    add(1'b0, DE,  N,           N,           N,           N,           1'b1, 1'b0, 32'h80,       1'b1, 16'd3);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h80,       1'b0, 16'd3);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h80,       1'b0, 16'd3);
    add(1'b0, S0,  32'h84,      32'h90,      32'h104,     N,           1'b1, 1'b1, 32'h84,       1'b1, 16'd4);
    add(1'b0, S0,  N,           32'h94,      N,           N,           1'b1, 1'b1, 32'h94,       1'b1, 16'd5);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, 32'h94,       1'b1, 16'd5);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h94,       1'b0, 16'd5);
    add(1'b0, S0,  N,           N,           N,           32'h400,     1'b1, 1'b1, 32'h400,      1'b1, 16'd6);
    add(1'b0, S0,  N,           N,           32'h500,     N,           1'b1, 1'b0, 32'h400,      1'b1, 16'd6);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h400,      1'b0, 16'd6);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h400,      1'b0, 16'd6);
    add(1'b0, EXE, N,           N,           N,           32'h600,     1'b0, 1'b0, 32'h400,      1'b1, 16'd6);
    add(1'b0, RR,  N,           N,           32'h700,     N,           1'b0, 1'b0, 32'h400,      1'b1, 16'd6);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b1, 32'h600,      1'b1, 16'd7);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, 32'h600,      1'b1, 16'd7);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h600,      1'b0, 16'd7);
    add(1'b0, MUL, N,           32'hA0,      N,           32'h800,     1'b1, 1'b1, 32'hA0,       1'b1, 16'd8);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, 32'hA0,       1'b1, 16'd8);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'hA0,       1'b0, 16'd8);
    add(1'b0, S0,  N,           N,           32'h900,     32'hA00,     1'b1, 1'b1, 32'h900,      1'b1, 16'd9);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, 32'h900,      1'b1, 16'd9);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, 32'h900,      1'b0, 16'd9);
    add(1'b0, S0,  N,           N,           32'hB00,     N,           1'b1, 1'b1, 32'hB00,      1'b1, 16'd10);
    add(1'b1, S0,  N,           N,           N,           N,           1'b1, 1'b0, N,            1'b0, 16'd0);
    add(1'b1, S0,  N,           N,           N,           N,           1'b1, 1'b0, N,            1'b0, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b1, RP,           1'b1, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, RP,           1'b1, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, RP,           1'b0, 16'd0);
    add(1'b0, MEM, N,           N,           N,           32'hC00,     1'b0, 1'b0, RP,           1'b1, 16'd0);
    add(1'b1, S0,  N,           N,           N,           N,           1'b1, 1'b0, N,            1'b0, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b1, RP,           1'b1, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b1, 1'b0, RP,           1'b1, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, RP,           1'b0, 16'd0);
    add(1'b0, S0,  N,           N,           N,           N,           1'b0, 1'b0, RP,           1'b0, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("fet_stall", i, {31'd0, bus.fet_stall}, {31'd0, |vecs[i].st});
      @(posedge clk);
      #1;
      exp_c = CNT_EN ? vecs[i].ec : 16'd0;
      chk("fet_flush",   i, {31'd0, bus.fet_flush},   {31'd0, vecs[i].ef});
      chk("redir_valid", i, {31'd0, bus.redir_valid}, {31'd0, vecs[i].ev});
      chk("redir_pc",    i, bus.redir_pc,             vecs[i].ep);
      chk("redir_busy",  i, {31'd0, bus.redir_busy},  {31'd0, vecs[i].eb});
      chk("redir_cnt",   i, {16'd0, bus.redir_cnt},   {16'd0, exp_c});
    end

    // Long stall on a pending jump, then measure release-to-issue latency.
    @(negedge clk);
    drive(idle_v);
    bus.jmp_req = 1'b1;
    bus.jmp_pc  = 32'hD00;
    bus.de_stall = 1'b1;
    @(negedge clk);
    bus.jmp_req = 1'b0;
    bus.jmp_pc  = N;
    seen_early = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.redir_valid) seen_early = 1'b1;
    end
    chk("pend_no_issue", 100, {31'd0, seen_early}, 32'd0);
    chk("pend_busy",     100, {31'd0, bus.redir_busy}, 32'd1);
    @(negedge clk);
    bus.de_stall = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 5 && !got; k++) begin
      @(posedge clk);
      #1;
      if (bus.redir_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("pend_latency", 101, lat, 32'd1);
    chk("pend_pc",      101, bus.redir_pc, 32'hD00);
    exp_c = CNT_EN ? 16'd1 : 16'd0;
    chk("pend_cnt",     101, {16'd0, bus.redir_cnt}, {16'd0, exp_c});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
